// File: rtl/weight_thresh_pipe.sv
// -----------------------------------------------------------------------------
// weight_thresh_pipe
//   Pipelined Hamming-weight unit for the PROM ECC path. Counts the ones in a
//   WIDTH-bit word and flags WEIGHT <= THRESH. In per-word mode (MODE=0) every
//   valid word produces a result. In frame mode (MODE=1) the weights of a
//   SOF..EOF run of words are summed into a saturating accumulator, and one
//   result is produced on the EOF word.
//
//   Latency is 3 clocks (word sampled at edge n -> OUT_VALID after edge n+3).
//   The unit accepts one word per clock and has no back-pressure.
//
// Ports
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   CLR        synchronous flush of the pipeline valids and the frame accumulator
//   V_VALID    qualifies V / SOF / EOF / MODE
//   V          word to weigh
//   SOF, EOF   frame delimiters (only used when MODE=1)
//   MODE       0 = per-word, 1 = frame accumulate (travels with its word)
//   THRESH     compare threshold, sampled when the word reaches stage 3
//   OUT_VALID  one-cycle strobe: WEIGHT / WLTEQ / WZERO / SAT are new
//   WEIGHT     word weight or frame weight, zero-extended
//   WLTEQ      WEIGHT <= THRESH (unsigned)
//   WZERO      WEIGHT == 0
//   SAT        frame accumulator saturated during the reported frame
// -----------------------------------------------------------------------------
module weight_thresh_pipe #(
  parameter int WIDTH = 12,
  parameter int ACC_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             V_VALID,
  input  logic [WIDTH-1:0] V,
  input  logic             SOF,
  input  logic             EOF,
  input  logic             MODE,
  input  logic [ACC_W-1:0] THRESH,
  output logic             OUT_VALID,
  output logic [ACC_W-1:0] WEIGHT,
  output logic             WLTEQ,
  output logic             WZERO,
  output logic             SAT
);

  localparam int NG    = (WIDTH + 3) / 4;     // number of 4-bit groups
  localparam int PAD_W = NG * 4;
  localparam int WW_W  = $clog2(WIDTH + 1);   // word-weight width

  // ---------------------------------------------------------------------------
  // Stage 1: per-nibble popcounts. The top group is zero-padded.
  // ---------------------------------------------------------------------------
  logic [PAD_W-1:0] v_pad;
  logic [2:0]       grp_cnt_d [NG];
  logic [2:0]       grp_cnt_q [NG];
  logic             s1_valid_d, s1_sof_d, s1_eof_d, s1_mode_d;
  logic             s1_valid_q, s1_sof_q, s1_eof_q, s1_mode_q;

  always_comb begin
    v_pad            = '0;
    v_pad[WIDTH-1:0] = V;
  end

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    assign grp_cnt_d[gi] = {2'b00, v_pad[4*gi]}   + {2'b00, v_pad[4*gi+1]} +
                           {2'b00, v_pad[4*gi+2]} + {2'b00, v_pad[4*gi+3]};
  end

  always_comb begin
    // A word presented together with CLR is dropped.
    s1_valid_d = V_VALID & ~CLR;
    s1_sof_d   = SOF;
    s1_eof_d   = EOF;
    s1_mode_d  = MODE;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: sum of the group counts -> word weight.
  // ---------------------------------------------------------------------------
  logic [WW_W-1:0] s2_ww_d, s2_ww_q;
  logic            s2_valid_d, s2_sof_d, s2_eof_d, s2_mode_d;
  logic            s2_valid_q, s2_sof_q, s2_eof_q, s2_mode_q;

  always_comb begin
    s2_ww_d = '0;
    for (int i = 0; i < NG; i++) begin
      s2_ww_d = s2_ww_d + WW_W'(grp_cnt_q[i]);
    end
    s2_valid_d = s1_valid_q & ~CLR;
    s2_sof_d   = s1_sof_q;
    s2_eof_d   = s1_eof_q;
    s2_mode_d  = s1_mode_q;
  end

  // ---------------------------------------------------------------------------
  // Stage 3: frame accumulation, result selection and threshold compare.
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] acc_d, acc_q;
  logic             sat_f_d, sat_f_q;
  logic [ACC_W-1:0] ww_ext, acc_base, acc_new;
  logic [ACC_W:0]   acc_sum;
  logic             acc_ovf, frame_sat;
  logic             res_valid, res_sat;
  logic [ACC_W-1:0] res_weight;

  logic             s3_valid_d, s3_wlteq_d, s3_wzero_d, s3_sat_d;
  logic             s3_valid_q, s3_wlteq_q, s3_wzero_q, s3_sat_q;
  logic [ACC_W-1:0] s3_weight_d, s3_weight_q;

  always_comb begin
    ww_ext    = ACC_W'(s2_ww_q);
    // SOF restarts the frame: the word is added to zero rather than to ACC,
    // which also discards any frame still open. A word without SOF simply
    // extends whatever ACC holds (zero after reset/CLR).
    acc_base  = s2_sof_q ? '0 : acc_q;
    acc_sum   = {1'b0, acc_base} + {1'b0, ww_ext};
    acc_ovf   = acc_sum[ACC_W];
    acc_new   = acc_ovf ? '1 : acc_sum[ACC_W-1:0];
    // Sticky saturation flag; SOF clears the history but not its own overflow.
    frame_sat = acc_ovf | (~s2_sof_q & sat_f_q);

    acc_d      = acc_q;
    sat_f_d    = sat_f_q;
    res_valid  = 1'b0;
    res_weight = ww_ext;
    res_sat    = 1'b0;

    if (s2_valid_q) begin
      if (s2_mode_q) begin
        acc_d   = acc_new;
        sat_f_d = frame_sat;
        if (s2_eof_q) begin
          res_valid  = 1'b1;
          res_weight = acc_new;
          res_sat    = frame_sat;
        end
      end else begin
        // Per-word result; an open frame's ACC is left untouched.
        res_valid = 1'b1;
      end
    end

    if (CLR) begin
      acc_d     = '0;
      sat_f_d   = 1'b0;
      res_valid = 1'b0;
    end

    s3_valid_d  = res_valid;
    s3_weight_d = res_weight;
    s3_wlteq_d  = (res_weight <= THRESH);
    s3_wzero_d  = (res_weight == '0);
    s3_sat_d    = res_sat;
  end

  // ---------------------------------------------------------------------------
  // Output register: loads only on a valid result, otherwise holds.
  // ---------------------------------------------------------------------------
  logic             out_valid_d, out_valid_q;
  logic [ACC_W-1:0] weight_d, weight_q;
  logic             wlteq_d, wlteq_q, wzero_d, wzero_q, sat_d, sat_q;
  logic             out_load;

  always_comb begin
    out_load    = s3_valid_q & ~CLR;
    out_valid_d = out_load;
    weight_d    = out_load ? s3_weight_q : weight_q;
    wlteq_d     = out_load ? s3_wlteq_q  : wlteq_q;
    wzero_d     = out_load ? s3_wzero_q  : wzero_q;
    sat_d       = out_load ? s3_sat_q    : sat_q;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NG; i++) begin
        grp_cnt_q[i] <= '0;
      end
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eof_q    <= 1'b0;
      s1_mode_q   <= 1'b0;
      s2_ww_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_sof_q    <= 1'b0;
      s2_eof_q    <= 1'b0;
      s2_mode_q   <= 1'b0;
      acc_q       <= '0;
      sat_f_q     <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_weight_q <= '0;
      s3_wlteq_q  <= 1'b0;
      s3_wzero_q  <= 1'b0;
      s3_sat_q    <= 1'b0;
      out_valid_q <= 1'b0;
      weight_q    <= '0;
      wlteq_q     <= 1'b0;
      wzero_q     <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NG; i++) begin
        grp_cnt_q[i] <= grp_cnt_d[i];
      end
      s1_valid_q  <= s1_valid_d;
      s1_sof_q    <= s1_sof_d;
      s1_eof_q    <= s1_eof_d;
      s1_mode_q   <= s1_mode_d;
      s2_ww_q     <= s2_ww_d;
      s2_valid_q  <= s2_valid_d;
      s2_sof_q    <= s2_sof_d;
      s2_eof_q    <= s2_eof_d;
      s2_mode_q   <= s2_mode_d;
      acc_q       <= acc_d;
      sat_f_q     <= sat_f_d;
      s3_valid_q  <= s3_valid_d;
      s3_weight_q <= s3_weight_d;
      s3_wlteq_q  <= s3_wlteq_d;
      s3_wzero_q  <= s3_wzero_d;
      s3_sat_q    <= s3_sat_d;
      out_valid_q <= out_valid_d;
      weight_q    <= weight_d;
      wlteq_q     <= wlteq_d;
      wzero_q     <= wzero_d;
      sat_q       <= sat_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign WEIGHT    = weight_q;
  assign WLTEQ     = wlteq_q;
  assign WZERO     = wzero_q;
  assign SAT       = sat_q;

endmodule

// File: tb/tb_weight_thresh_pipe.sv
// -----------------------------------------------------------------------------
// tb_weight_thresh_pipe
//   Directed bench for weight_thresh_pipe. Two instances share all inputs:
//   dut (WIDTH=12, ACC_W=8) and dut4 (WIDTH=12, ACC_W=4, for saturation).
// -----------------------------------------------------------------------------
module tb_weight_thresh_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        v_valid;
  logic [11:0] v;
  logic        sof, eof, mode;
  logic [7:0]  thresh;
  logic [3:0]  thresh4;

  logic        ov, wlteq, wzero, sat;
  logic [7:0]  weight;
  logic        ov4, wlteq4, wzero4, sat4;
  logic [3:0]  weight4;

  int checks   = 0;
  int failures = 0;
  int n_le;
  int pc;

  assign thresh4 = thresh[3:0];

  always #5 clk = ~clk;

  weight_thresh_pipe #(.WIDTH(12), .ACC_W(8)) dut (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .V_VALID(v_valid), .V(v),
    .SOF(sof), .EOF(eof), .MODE(mode), .THRESH(thresh),
    .OUT_VALID(ov), .WEIGHT(weight), .WLTEQ(wlteq), .WZERO(wzero), .SAT(sat)
  );

  weight_thresh_pipe #(.WIDTH(12), .ACC_W(4)) dut4 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .V_VALID(v_valid), .V(v),
    .SOF(sof), .EOF(eof), .MODE(mode), .THRESH(thresh4),
    .OUT_VALID(ov4), .WEIGHT(weight4), .WLTEQ(wlteq4), .WZERO(wzero4), .SAT(sat4)
  );

  // Mixed-mode stream with bubbles: inputs at edge k, expected outputs after edge k.
  logic [11:0] t5_v    [11] = '{12'h003, 12'h000, 12'h00F, 12'h007, 12'h000, 12'h000,
                                12'h001, 12'h000, 12'h000, 12'h000, 12'h000};
  logic        t5_vv   [11] = '{1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0};
  logic        t5_sof  [11] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  logic        t5_eof  [11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  logic        t5_mode [11] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
  logic        t5_ov   [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0};
  logic [7:0]  t5_w    [11] = '{0, 0, 0, 0, 0, 4, 0, 0, 0, 6, 0};
  logic        t5_wl   [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  logic        t5_wz   [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vv, input logic [11:0] vec,
                       input logic s, input logic e, input logic m);
    v_valid = vv;
    v       = vec;
    sof     = s;
    eof     = e;
    mode    = m;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [7:0] ew,
                           input logic el, input logic ez, input logic es);
    check({tag, "_ov"},    32'(ov),     32'(ev));
    check({tag, "_w"},     32'(weight), 32'(ew));
    check({tag, "_wlteq"}, 32'(wlteq),  32'(el));
    check({tag, "_wzero"}, 32'(wzero),  32'(ez));
    check({tag, "_sat"},   32'(sat),    32'(es));
    $display("txn %s OUT_VALID=%0b WEIGHT=%0d WLTEQ=%0b WZERO=%0b SAT=%0b",
             tag, ov, weight, wlteq, wzero, sat);
  endtask

  task automatic check_out4(input string tag, input logic ev, input logic [3:0] ew,
                            input logic el, input logic ez, input logic es);
    check({tag, "_ov"},    32'(ov4),     32'(ev));
    check({tag, "_w"},     32'(weight4), 32'(ew));
    check({tag, "_wlteq"}, 32'(wlteq4),  32'(el));
    check({tag, "_wzero"}, 32'(wzero4),  32'(ez));
    check({tag, "_sat"},   32'(sat4),    32'(es));
    $display("txn %s OUT_VALID=%0b WEIGHT=%0d WLTEQ=%0b WZERO=%0b SAT=%0b",
             tag, ov4, weight4, wlteq4, wzero4, sat4);
  endtask

  // One MODE=0 word, then bubbles; result expected exactly 3 edges later.
  task automatic word0(input string tag, input logic [11:0] vec, input logic [7:0] ew,
                       input logic el, input logic ez);
    drive(1, vec, 0, 0, 0);
    tick;
    drive(0, 12'h000, 0, 0, 0);
    tick;
    tick;
    check({tag, "_early"}, 32'(ov), 32'd0);
    tick;
    check_out(tag, 1, ew, el, ez, 0);
    tick;
    check({tag, "_strobe"}, 32'(ov), 32'd0);
    check({tag, "_hold"}, 32'(weight), 32'(ew));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    thresh  = 8'd0;
    drive(0, 12'h000, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, 8'd0, 0, 0, 0);
    check_out4("reset4", 0, 4'd0, 0, 0, 0);
    rst_n = 1'b1;

    // ---- 1: exhaustive per-word, THRESH=2, back-to-back ----
    thresh = 8'd2;
    n_le   = 0;
    for (int k = 0; k < 4099; k++) begin
      if (k < 4096) drive(1, 12'(k), 0, 0, 0);
      else          drive(0, 12'h000, 0, 0, 0);
      tick;
      if (k >= 3) begin
        pc = $countones(12'(k - 3));
        check("t1_valid", 32'(ov), 32'd1);
        check("t1_weight", 32'(weight), 32'(pc));
        check("t1_wlteq", 32'(wlteq), 32'(pc <= 2));
        if (wlteq) n_le++;
      end else begin
        check("t1_lead", 32'(ov), 32'd0);
      end
    end
    check("t1_count79", 32'(n_le), 32'd79);
    $display("txn t1 exhaustive words=4096 wlteq_count=%0d", n_le);
    drive(0, 12'h000, 0, 0, 0);
    tick;

    // ---- 2: per-word boundaries ----
    thresh = 8'd2;
    word0("t2_zero", 12'h000, 8'd0, 1, 1);
    thresh = 8'd12;
    word0("t2_fff_t12", 12'hFFF, 8'd12, 1, 0);
    thresh = 8'd11;
    word0("t2_fff_t11", 12'hFFF, 8'd12, 0, 0);

    // ---- 3: three-word frame, weight 1+2+0 ----
    thresh = 8'd3;
    drive(1, 12'h001, 1, 0, 1); tick;
    drive(1, 12'h003, 0, 0, 1); tick;
    drive(1, 12'h000, 0, 1, 1); tick;
    drive(0, 12'h000, 0, 0, 0); tick;
    check("t3_no_out_w1", 32'(ov), 32'd0);
    tick;
    check("t3_no_out_w2", 32'(ov), 32'd0);
    tick;
    check_out("t3_frame", 1, 8'd3, 1, 0, 0);

    // ---- 4: saturation with ACC_W=4 (12+12 -> 15), then clean frame ----
    thresh = 8'd20;
    drive(1, 12'hFFF, 1, 0, 1); tick;
    drive(1, 12'hFFF, 0, 1, 1); tick;
    drive(0, 12'h000, 0, 0, 0); tick;
    tick;
    check("t4_no_out_sof", 32'(ov4), 32'd0);
    tick;
    check_out4("t4_sat4", 1, 4'd15, 0, 0, 1);
    check_out("t4_acc8", 1, 8'd24, 0, 0, 0);
    drive(1, 12'h001, 1, 1, 1); tick;
    drive(0, 12'h000, 0, 0, 0); tick;
    tick;
    tick;
    check_out4("t4_single4", 1, 4'd1, 1, 0, 0);
    check_out("t4_single8", 1, 8'd1, 1, 0, 0);

    // ---- 5: bubbles and interleaved MODE 0/1 words ----
    thresh = 8'd3;
    for (int k = 0; k < 11; k++) begin
      drive(t5_vv[k], t5_v[k], t5_sof[k], t5_eof[k], t5_mode[k]);
      tick;
      check($sformatf("t5_ov_e%0d", k), 32'(ov), 32'(t5_ov[k]));
      if (t5_ov[k]) check_out($sformatf("t5_e%0d", k), 1, t5_w[k], t5_wl[k], t5_wz[k], 0);
    end

    // ---- 6a: CLR with two words in flight (and one presented with CLR) ----
    drive(1, 12'h001, 0, 0, 0); tick;
    drive(1, 12'h003, 0, 0, 0); tick;
    clr = 1'b1;
    drive(1, 12'h007, 0, 0, 0); tick;
    check("t6_clr_ov", 32'(ov), 32'd0);
    clr = 1'b0;
    drive(0, 12'h000, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check($sformatf("t6_flushed_e%0d", k), 32'(ov), 32'd0);
      check($sformatf("t6_flushed4_e%0d", k), 32'(ov4), 32'd0);
    end
    check("t6_hold_w", 32'(weight), 32'd6);
    $display("txn t6 clr flushed, WEIGHT held=%0d", weight);

    // ---- 6b: asynchronous reset in the middle of a frame ----
    drive(1, 12'h00F, 1, 0, 1); tick;
    drive(1, 12'h0FF, 0, 0, 1); tick;
    drive(0, 12'h000, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_out("t6_async_rst", 0, 8'd0, 0, 0, 0);
    check_out4("t6_async_rst4", 0, 4'd0, 0, 0, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive(1, 12'h003, 0, 1, 1); tick;
    drive(0, 12'h000, 0, 0, 0); tick;
    tick;
    check("t6_post_rst_quiet", 32'(ov), 32'd0);
    tick;
    check_out("t6_clean_frame", 1, 8'd2, 1, 0, 0);
    check_out4("t6_clean_frame4", 1, 4'd2, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
